// File: rtl/ram_1r1w_pkg.sv
// rtl/ram_1r1w_pkg.sv - shared geometry parameters and types for the 1R1W block RAM
package ram_1r1w_pkg;

  localparam int BLOCKSIZE = 10;
  localparam int ADDR_W    = BLOCKSIZE + 1;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int DATA_W    = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ram_1r1w_array.sv
// rtl/ram_1r1w_array.sv - inferred block-RAM storage with registered, read-first output
module ram_1r1w_array
  import ram_1r1w_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_W,
  parameter int WIDTH     = DATA_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] w_addr,
  input  logic [WIDTH-1:0]     w_din,
  input  logic [ADDR_BITS-1:0] r_addr,
  output logic [WIDTH-1:0]     rd
);

  // Block RAM has no content reset; the declaration initialiser gives the power-up zero image.
  logic [WIDTH-1:0] mem [1 << ADDR_BITS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_din;
    end
    rd <= mem[r_addr];
  end

endmodule

// File: rtl/ram_1r1w.sv
// rtl/ram_1r1w.sv - 1R1W RAM wrapper adding read-output reset and write-first bypass
module ram_1r1w
  import ram_1r1w_pkg::*;
#(
  parameter int BLOCKSIZE = ram_1r1w_pkg::BLOCKSIZE,
  parameter int DATA_W    = ram_1r1w_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BLOCKSIZE:0]   w_addr,
  input  logic [DATA_W-1:0]    w_din,
  input  logic                 w_enb,
  input  logic [BLOCKSIZE:0]   r_addr,
  output logic [DATA_W-1:0]    r_dout
);

  logic              we;
  logic              zero_q;
  logic              coll_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] raw;

  assign we = w_enb && rst;

  ram_1r1w_array #(
    .ADDR_BITS(BLOCKSIZE + 1),
    .WIDTH    (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .w_addr(w_addr),
    .w_din (w_din),
    .r_addr(r_addr),
    .rd    (raw)
  );

  // The array returns old data on a same-address collision; remember the edge's
  // collision and write data so the output can present the new word instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      zero_q <= 1'b1;
      coll_q <= 1'b0;
      din_q  <= '0;
    end else begin
      zero_q <= 1'b0;
      coll_q <= w_enb && (w_addr == r_addr);
      din_q  <= w_din;
    end
  end

  // Driven only from registers, so r_dout moves solely on clock edges.
  always_comb begin
    r_dout = raw;
    if (zero_q) begin
      r_dout = '0;
    end else if (coll_q) begin
      r_dout = din_q;
    end
  end

endmodule

// File: tb/tb_ram_1r1w.sv
// tb/tb_ram_1r1w.sv - randomized self-checking bench for ram_1r1w against an array model
module tb_ram_1r1w;
  import ram_1r1w_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  addr_t w_addr;
  data_t w_din;
  logic  w_enb;
  addr_t r_addr;
  data_t r_dout;

  int tests = 0;
  int fails = 0;

  data_t model [DEPTH];

  ram_1r1w dut (
    .clk   (clk),
    .rst   (rst),
    .w_addr(w_addr),
    .w_din (w_din),
    .w_enb (w_enb),
    .r_addr(r_addr),
    .r_dout(r_dout)
  );

  always #5 clk = ~clk;

  // One clock edge with the current inputs; exp is what r_dout must show afterwards.
  task automatic tick(output data_t exp);
    if (!rst) exp = '0;
    else if (w_enb && (w_addr == r_addr)) exp = w_din;
    else exp = model[r_addr];
    if (rst && w_enb) model[w_addr] = w_din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data_t exp;
    addr_t wa;
    wa = addr_t'($urandom_range(DEPTH - 1));
    rst = 1'b0; w_enb = 1'b1; w_addr = wa;
    for (int i = 0; i < 3; i++) begin
      r_addr = addr_t'($urandom_range(DEPTH - 1));
      w_din  = data_t'($urandom);
      tick(exp);
      tests++;
      if (r_dout !== 32'h0) begin
        fails++;
        $display("FAIL reset_dout cycle %0d: got %h want 0", i, r_dout);
      end
    end
    rst = 1'b1; w_enb = 1'b0; r_addr = wa;
    tick(exp);
    tests++;
    if (r_dout !== 32'h0) begin
      fails++;
      $display("FAIL reset_write_suppressed addr %h: got %h want 0", wa, r_dout);
    end
  endtask

  task automatic test_write_disable();
    data_t exp;
    w_enb = 1'b0; w_addr = 11'h7FF; w_din = 32'hFFFFFFFF; r_addr = 11'h000;
    tick(exp);
    r_addr = 11'h7FF;
    tick(exp);
    tests++;
    if (r_dout !== 32'h0) begin
      fails++;
      $display("FAIL write_disable: got %h want 0", r_dout);
    end
  endtask

  task automatic test_fill_readback();
    data_t exp;
    int bad = 0;
    w_enb = 1'b1; r_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_addr = addr_t'(i);
      w_din  = data_t'(i * 32'h01010101 + 32'hA5);
      r_addr = addr_t'(i + 1);
      tick(exp);
    end
    w_enb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = addr_t'(i);
      tick(exp);
      tests++;
      if (r_dout !== data_t'(i * 32'h01010101 + 32'hA5) && bad < 10) begin
        bad++;
        fails++;
        $display("FAIL fill_readback addr %h: got %h want %h", i, r_dout,
                 data_t'(i * 32'h01010101 + 32'hA5));
      end else if (r_dout !== data_t'(i * 32'h01010101 + 32'hA5)) begin
        fails++;
      end
    end
  endtask

  task automatic test_collision();
    data_t exp;
    w_enb = 1'b1; w_addr = 11'h155; w_din = 32'h11111111; r_addr = 11'h000;
    tick(exp);
    w_din = 32'hDEADBEEF; r_addr = 11'h155;
    tick(exp);
    tests++;
    if (r_dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL collision_bypass: got %h want deadbeef", r_dout);
    end
    w_enb = 1'b0; r_addr = 11'h000;
    tick(exp);
    r_addr = 11'h155;
    tick(exp);
    tests++;
    if (r_dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL collision_persist: got %h want deadbeef", r_dout);
    end
  endtask

  task automatic test_reset_midstream();
    data_t exp;
    w_enb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_addr = addr_t'(i);
      rst = (i != 8);
      tick(exp);
      tests++;
      if (r_dout !== exp || (i == 8 && r_dout !== 32'h0)) begin
        fails++;
        $display("FAIL reset_midstream addr %h: got %h want %h", i, r_dout, exp);
      end
    end
    rst = 1'b1;
    r_addr = 11'h008;
    tick(exp);
    tests++;
    if (r_dout !== data_t'(8 * 32'h01010101 + 32'hA5)) begin
      fails++;
      $display("FAIL reset_midstream_mem: got %h want %h", r_dout,
               data_t'(8 * 32'h01010101 + 32'hA5));
    end
  endtask

  task automatic test_boundaries();
    data_t exp;
    w_enb = 1'b1; r_addr = 11'h400;
    w_addr = 11'h000; w_din = 32'hCAFEF00D;
    tick(exp);
    w_addr = 11'h7FF; w_din = 32'h12345678;
    tick(exp);
    w_enb = 1'b0; r_addr = 11'h000;
    tick(exp);
    tests++;
    if (r_dout !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL boundary_low: got %h want cafef00d", r_dout);
    end
    r_addr = 11'h7FF;
    tick(exp);
    tests++;
    if (r_dout !== 32'h12345678) begin
      fails++;
      $display("FAIL boundary_high: got %h want 12345678", r_dout);
    end
  endtask

  task automatic test_random();
    data_t exp;
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(49) != 0);
      w_enb  = $urandom_range(1);
      w_addr = addr_t'($urandom_range(15)) | 11'h7F0;
      r_addr = addr_t'($urandom_range(15)) | 11'h7F0;
      w_din  = data_t'($urandom);
      tick(exp);
      tests++;
      if (r_dout !== exp) begin
        fails++;
        if (bad < 10) $display("FAIL random cycle %0d: got %h want %h", i, r_dout, exp);
        bad++;
      end
    end
    rst = 1'b1; w_enb = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b0; w_enb = 1'b0; w_addr = '0; w_din = '0; r_addr = '0;
    #1;
    test_reset();
    test_write_disable();
    test_fill_readback();
    test_collision();
    test_reset_midstream();
    test_boundaries();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
